// File: rtl/mult_seq_unit_pkg.sv
// Shared definitions for the sequential MULTU unit: controller states and default width.
`ifndef MULT_SEQ_DEFS_SV
`define MULT_SEQ_DEFS_SV

package mult_seq_unit_pkg;

    // Default operand width of the multiplier datapath.
    localparam int unsigned MULT_WIDTH = 32;

    // Adder lookahead group size; WIDTH must be a multiple of this.
    localparam int unsigned CLA_GROUP = 4;

    // Controller states; encodings are fixed so HI/LO control decodes stay stable.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

endpackage

`endif

// File: rtl/mult_seq_unit_cla.sv
// Carry-lookahead adder: 4-bit lookahead groups with group carries rippling between them.
`ifndef CLA_ADDER32_SV
`define CLA_ADDER32_SV

module CLA_Adder32
    import mult_seq_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned GROUPS = WIDTH / CLA_GROUP;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c;
    logic [GROUPS:0]  gc;

    assign g     = a & b;
    assign p     = a ^ b;
    assign gc[0] = cin;

    // Per-group lookahead: every internal carry and the group carry-out come
    // straight from generate/propagate terms and the group carry-in.
    for (genvar k = 0; k < GROUPS; k++) begin : g_grp
        localparam int unsigned B = CLA_GROUP * k;

        assign c[B]     = gc[k];
        assign c[B + 1] = g[B] | (p[B] & gc[k]);
        assign c[B + 2] = g[B + 1] | (p[B + 1] & g[B]) | (p[B + 1] & p[B] & gc[k]);
        assign c[B + 3] = g[B + 2] | (p[B + 2] & g[B + 1]) | (p[B + 2] & p[B + 1] & g[B])
                        | (p[B + 2] & p[B + 1] & p[B] & gc[k]);
        assign gc[k + 1] = g[B + 3] | (p[B + 3] & g[B + 2]) | (p[B + 3] & p[B + 2] & g[B + 1])
                         | (p[B + 3] & p[B + 2] & p[B + 1] & g[B])
                         | (p[B + 3] & p[B + 2] & p[B + 1] & p[B] & gc[k]);
    end

    assign sum  = p ^ c;
    assign cout = gc[GROUPS];

endmodule

`endif

// File: rtl/mult_seq_unit.sv
// Sequential unsigned shift-add multiplier for MULTU: one add per cycle into HI/LO.
module mult_seq_unit
    import mult_seq_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mult_state_e      state;
    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             carry;

    // Add the multiplicand only when the current multiplier bit (lo[0]) is set.
    assign addend = lo[0] ? mcand_r : '0;

    CLA_Adder32 #(
        .WIDTH (WIDTH)
    ) u_add (
        .a    (hi),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (carry)
    );

    // Controller, iteration counter and HI/LO shift register; busy/done are registered state decodes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            counter <= '0;
            mcand_r <= '0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mcand_r <= mcand;
                        lo      <= mplier;
                        hi      <= '0;
                        counter <= CNT_W'(WIDTH - 1);
                        state   <= ST_RUN;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state   <= ST_IDLE;
                        hi      <= '0;
                        lo      <= '0;
                        counter <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end else begin
                        // {carry, sum, lo} shifted right by one; lo[0] has been consumed.
                        hi      <= {carry, sum[WIDTH-1:1]};
                        lo      <= {sum[0], lo[WIDTH-1:1]};
                        counter <= counter - 1'b1;
                        if (counter == '0) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_unit.sv
// Self-checking bench for mult_seq_unit against a plain 64-bit multiply reference.
module tb_mult_seq_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    // 100 MHz free-running clock.
    always #5 clk = ~clk;

    mult_seq_unit #(
        .WIDTH (32)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .abort  (abort),
        .mcand  (mcand),
        .mplier (mplier),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] wa;
        logic [63:0] wb;
        wa = {32'd0, a};
        wb = {32'd0, b};
        return wa * wb;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands with start for one edge; the unit must be busy right after.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input string tag);
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mcand  = $urandom;
        mplier = $urandom;
        check_val({tag, "_busy_e0"}, 64'(busy), 64'd1);
        check_val({tag, "_done_e0"}, 64'(done), 64'd0);
    endtask

    // Count edges until done (bounded), optionally injecting a start at edge count 'inject'.
    task automatic wait_done(input logic [31:0] a, input logic [31:0] b, input string tag,
                             input int inject);
        int          n;
        int          gaps;
        logic [63:0] exp;
        n    = 0;
        gaps = 0;
        exp  = ref_prod(a, b);
        while (done !== 1'b1 && n < 100) begin
            if (n == inject) begin
                start  = 1'b1;
                mcand  = 32'hDEAD_BEEF;
                mplier = 32'h1234_5678;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (done !== 1'b1 && busy !== 1'b1) gaps++;
        end
        check_val({tag, "_latency"}, 64'(n), 64'd32);
        check_val({tag, "_busy_gap"}, 64'(gaps), 64'd0);
        check_val({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check_val({tag, "_hi"}, 64'(hi), 64'(exp[63:32]));
        check_val({tag, "_lo"}, 64'(lo), 64'(exp[31:0]));
    endtask

    // One edge after done with no start: pulse ends and the product is held.
    task automatic after_done(input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] exp;
        exp = ref_prod(a, b);
        @(posedge clk);
        #1;
        check_val({tag, "_done_pulse"}, 64'(done), 64'd0);
        check_val({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_hold"}, {hi, lo}, exp);
    endtask

    // Watch a window of edges and require no done pulse and no busy.
    task automatic no_done(input string tag);
        int pulses;
        int busies;
        pulses = 0;
        busies = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
            if (busy === 1'b1) busies++;
        end
        check_val({tag, "_no_done"}, 64'(pulses), 64'd0);
        check_val({tag, "_no_busy"}, 64'(busies), 64'd0);
    endtask

    logic [31:0] dir_a [5] = '{32'd3, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32'h0001_0000};
    logic [31:0] dir_b [5] = '{32'd5, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0002, 32'h0001_0000};

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;

        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        mcand  = '0;
        mplier = '0;
        #2;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed operand set, including carry-out and zero cases.
        for (int i = 0; i < 5; i++) begin
            launch(dir_a[i], dir_b[i], $sformatf("dir%0d", i));
            wait_done(dir_a[i], dir_b[i], $sformatf("dir%0d", i), -1);
            after_done(dir_a[i], dir_b[i], $sformatf("dir%0d", i));
        end

        // abort while idle must not disturb the held product.
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_val("idle_abort_busy", 64'(busy), 64'd0);
        check_val("idle_abort_hold", {hi, lo}, ref_prod(dir_a[4], dir_b[4]));

        // Randomized operands, with occasional forced extremes.
        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 3) ra = 32'hFFFF_FFFF;
            if (i == 6) rb = 32'h0000_0001;
            launch(ra, rb, $sformatf("rnd%0d", i));
            wait_done(ra, rb, $sformatf("rnd%0d", i), -1);
            after_done(ra, rb, $sformatf("rnd%0d", i));
        end

        // start during RUN is ignored; then a start in the DONE cycle restarts with no IDLE gap.
        launch(32'd7, 32'd9, "ign");
        wait_done(32'd7, 32'd9, "ign", 10);
        launch(32'h0001_0003, 32'hFFFF_0001, "b2b");
        wait_done(32'h0001_0003, 32'hFFFF_0001, "b2b", -1);
        after_done(32'h0001_0003, 32'hFFFF_0001, "b2b");

        // abort mid-RUN clears HI/LO and suppresses done.
        launch($urandom, $urandom, "abt");
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_val("abt_busy", 64'(busy), 64'd0);
        check_val("abt_done", 64'(done), 64'd0);
        check_val("abt_hilo", {hi, lo}, 64'd0);
        no_done("abt");

        // abort and start together in RUN: abort wins.
        launch(32'hFFFF_FFFF, 32'h0000_00FF, "abs");
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        abort  = 1'b1;
        start  = 1'b1;
        mcand  = 32'd5;
        mplier = 32'd5;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        check_val("abs_busy", 64'(busy), 64'd0);
        check_val("abs_hilo", {hi, lo}, 64'd0);
        no_done("abs");

        // Asynchronous reset mid-RUN takes effect before the next edge.
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, "rst");
        repeat (19) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        check_val("rst_mid_busy", 64'(busy), 64'd0);
        check_val("rst_mid_done", 64'(done), 64'd0);
        check_val("rst_mid_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        no_done("rst");
        launch(32'h0001_0000, 32'h0001_0000, "post_rst");
        wait_done(32'h0001_0000, 32'h0001_0000, "post_rst", -1);
        check_val("post_rst_hilo", {hi, lo}, 64'h0000_0001_0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
